// File: rtl/shared_dmem_arbiter.sv
// Round-robin arbiter granting N cores one at a time onto a shared 1-cycle-latency data RAM.
// A sticky per-core lock keeps lw/modify/sw sequences atomic across the whole core set.
module shared_dmem_arbiter #(
    parameter int NCORES = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        req,
    input  logic [NCORES-1:0]        we,
    input  logic [NCORES-1:0]        lock,
    input  logic [NCORES*ADDR_W-1:0] addr,
    input  logic [NCORES*DATA_W-1:0] wdata,
    output logic [NCORES-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [IDX_W-1:0]         owner,
    output logic                     locked,
    output logic [CNT_W-1:0]         stall_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [NCORES-1:0] ONE_HOT0 = NCORES'(1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   g_idx;
    logic               we_g;
    logic               lock_g;
    logic [ADDR_W-1:0]  addr_g;
    logic [DATA_W-1:0]  wdata_g;
    logic               locked_q;
    logic [IDX_W-1:0]   owner_q;
    logic [NCORES-1:0]  done_prev;
    logic [CNT_W-1:0]   stall_q;

    logic [NCORES-1:0]  eligible;
    logic [NCORES-1:0]  grant_mask;
    logic [NCORES-1:0]  done_vec;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               release_lock;
    logic               stall_inc;
    int                 idx;

    // Release is only seen once the owner is idle with its lock flag low, so an owner's
    // unlocked-flag access (req=1, lock=0) keeps the lock held.
    always_comb begin
        release_lock = locked_q && (state == IDLE) && !lock[owner_q] && !req[owner_q];
        eligible     = req & ~done_prev;
        if (locked_q && !release_lock) begin
            eligible = eligible & (ONE_HOT0 << owner_q);
        end
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 0; k < NCORES; k++) begin
            idx = (int'(rr_ptr) + k) % NCORES;
            if (!pick_vld && eligible[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        done_vec   = (state == RESP) ? (ONE_HOT0 << g_idx) : '0;
        grant_mask = '0;
        if (state == IDLE) begin
            if (pick_vld) grant_mask = ONE_HOT0 << pick_idx;
        end else begin
            grant_mask = ONE_HOT0 << g_idx;
        end
        stall_inc = |(req & ~grant_mask);
    end

    assign done      = done_vec;
    assign rdata     = (state == RESP && !we_g) ? mem_rdata : '0;
    assign mem_en    = (state == ISSUE);
    assign mem_we    = (state == ISSUE) && we_g;
    assign mem_addr  = addr_g;
    assign mem_wdata = wdata_g;
    assign owner     = owner_q;
    assign locked    = locked_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            g_idx     <= '0;
            we_g      <= 1'b0;
            lock_g    <= 1'b0;
            addr_g    <= '0;
            wdata_g   <= '0;
            locked_q  <= 1'b0;
            owner_q   <= '0;
            done_prev <= '0;
            stall_q   <= '0;
        end else begin
            done_prev <= done_vec;
            if (state == IDLE && pick_vld) begin
                g_idx   <= pick_idx;
                we_g    <= we[pick_idx];
                lock_g  <= lock[pick_idx];
                addr_g  <= addr[pick_idx*ADDR_W +: ADDR_W];
                wdata_g <= wdata[pick_idx*DATA_W +: DATA_W];
            end
            if (release_lock) begin
                locked_q <= 1'b0;
                owner_q  <= '0;
            end
            if (state == RESP) begin
                if (int'(g_idx) == NCORES - 1) rr_ptr <= '0;
                else                           rr_ptr <= g_idx + 1'b1;
                if (lock_g) begin
                    locked_q <= 1'b1;
                    owner_q  <= g_idx;
                end
            end
            if (stall_inc && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Scoreboard bench for shared_dmem_arbiter: 4 cores, 4-bit stall counter, behavioural 1-cycle RAM.
`timescale 1ns/1ps
module tb_shared_dmem_arbiter;
    localparam int NC = 4;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] req = '0, we = '0, lock = '0;
    logic [NC*AW-1:0] addr = '0;
    logic [NC*DW-1:0] wdata = '0;
    logic [NC-1:0] done;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, locked;
    logic [AW-1:0] mem_addr;
    logic [1:0]    owner;
    logic [CW-1:0] stall_cnt;
    logic [DW-1:0] mem [512];

    shared_dmem_arbiter #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .locked(locked),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        mem_rdata <= '0;
        for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE_0000 | i;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct { int core; logic [DW-1:0] rdata; } exp_t;
    exp_t sbq[$];
    bit   sb_on = 1'b0;
    int   total = 0, bad = 0, dones = 0, cyc = 0;
    int   last_cyc[NC], period[NC];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req_v);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every done pulse is matched against the next expected grant.
    always @(negedge clk) begin : mon
        int c;
        exp_t e;
        if (!rst && done != '0) begin
            c = 0;
            for (int i = 0; i < NC; i++) if (done[i]) c = i;
            dones++;
            chk("done_onehot", 64'($onehot(done)), 64'd1);
            period[c] = cyc - last_cyc[c];
            last_cyc[c] = cyc;
            if (locked) chk("lock_owner_only", c, 64'(owner));
            if (sb_on) begin
                if (sbq.size() == 0) chk("unexpected_done_core", c, -1);
                else begin
                    e = sbq.pop_front();
                    chk("grant_core", c, e.core);
                    chk("rdata", rdata, e.rdata);
                end
            end
        end
    end

    task automatic push(input int c, input logic [DW-1:0] d);
        exp_t e;
        e.core = c; e.rdata = d;
        sbq.push_back(e);
    endtask

    task automatic access(input int c, input bit w, input bit lk, input int a,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat);
        bit got;
        got = 1'b0; lat = 0; rd = '0;
        we[c] = w; lock[c] = lk; addr[c*AW +: AW] = a[AW-1:0];
        wdata[c*DW +: DW] = wd; req[c] = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (done[c]) begin got = 1'b1; rd = rdata; end
        end
        if (!got) chk("access_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        req[c] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rmw(input int c, input bit lk, input int a, input int n);
        logic [DW-1:0] v, dummy;
        int lat;
        for (int k = 0; k < n; k++) begin
            access(c, 1'b0, lk, a, '0, v, lat);
            access(c, 1'b1, lk, a, v + 1, dummy, lat);
            lock[c] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] rd;
        int lat, n, d0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        sb_on = 1'b1;

        // store then load, same core, same address
        push(0, 32'h0);
        fork
            access(0, 1'b1, 1'b0, 5, 32'hA, rd, lat);
            begin
                @(posedge clk); #1;
                chk("issue_mem_en", mem_en, 1);
                chk("issue_mem_we", mem_we, 1);
                chk("issue_mem_addr", mem_addr, 5);
                chk("issue_mem_wdata", mem_wdata, 32'hA);
            end
        join
        chk("store_latency", lat, 3);
        push(0, 32'hA);
        access(0, 1'b0, 1'b0, 5, '0, rd, lat);
        chk("load_latency", lat, 3);
        chk("load_after_store", rd, 32'hA);

        // two cores loading continuously from reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, 32'hC0DE_0007);
            push(1, 32'hC0DE_0009);
        end
        addr[0*AW +: AW] = 9'd7;
        addr[1*AW +: AW] = 9'd9;
        we = '0; lock = '0;
        req = 4'b0011;
        repeat (3) @(posedge clk);
        #1 chk("stall_after_3", stall_cnt, 3);
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clk);
            if (done[1]) n++;
        end
        req = '0;
        chk("rr_core1_dones", n, 3);
        chk("period_core0", period[0], 6);
        chk("period_core1", period[1], 6);
        chk("stall_saturated", stall_cnt, 4'hF);
        repeat (2) @(posedge clk);
        #1 chk("queue_drained_rr", sbq.size(), 0);

        // four cores, core2 takes the lock on its second grant
        do_reset();
        for (int i = 0; i < NC; i++) addr[i*AW +: AW] = AW'(16 + i);
        begin
            int order[12] = '{0, 1, 2, 3, 0, 1, 2, 2, 2, 3, 0, 1};
            foreach (order[i]) push(order[i], 32'hC0DE_0010 + order[i]);
        end
        req = 4'b1111;
        n = 0;
        for (int k = 0; k < 400 && n < 12; k++) begin
            @(negedge clk);
            if (done != '0) begin
                n++;
                if (n == 3) lock[2] = 1'b1;
                if (n == 8) begin
                    chk("locked_by_2", locked, 1);
                    chk("owner_is_2", owner, 2);
                end
                if (n == 9) begin req[2] = 1'b0; lock[2] = 1'b0; end
                if (n == 12) req = '0;
            end
        end
        chk("lock_seq_count", n, 12);
        @(posedge clk); #1;
        chk("lock_released", locked, 0);
        chk("queue_drained_lock", sbq.size(), 0);

        // atomic read-modify-write from two cores, then the same without locking
        do_reset();
        sb_on = 1'b0;
        d0 = dones;
        fork
            rmw(0, 1'b1, 40, 5);
            rmw(1, 1'b1, 40, 5);
        join
        chk("rmw_lock_mem", mem[40], 32'hC0DE_0028 + 10);
        chk("rmw_lock_dones", dones - d0, 20);
        chk("rmw_lock_free", locked, 0);
        d0 = dones;
        fork
            rmw(0, 1'b0, 41, 5);
            rmw(1, 1'b0, 41, 5);
        join
        chk("rmw_nolock_dones", dones - d0, 20);

        // reset while a locked store is in ISSUE
        sb_on = 1'b1;
        push(0, 32'hC0DE_003C);
        access(0, 1'b0, 1'b1, 60, '0, rd, lat);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_owner", owner, 0);
        we[0] = 1'b1; addr[0*AW +: AW] = 9'd61; wdata[0*DW +: DW] = 32'h55; req[0] = 1'b1;
        @(posedge clk); #1;
        chk("mid_issue_mem_en", mem_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_locked", locked, 0);
        chk("abort_stall", stall_cnt, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        req = '0; lock = '0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("abort_no_pending", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
